// File: rtl/pipeline_ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier and
// restoring divider, registering the result and ID sideband into EX/MEM.
module pipeline_ex_stage #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_ID,
    input  logic [DW-1:0] pc_ID,
    input  logic [DW-1:0] reg_data1_ID,
    input  logic [DW-1:0] reg_data2_ID,
    input  logic [DW-1:0] imm_ID,
    input  logic [4:0]    rd_ID,
    input  logic [3:0]    alu_ctrl_ID,
    input  logic          alu_a_sel_ID,
    input  logic          alu_b_sel_ID,
    input  logic [2:0]    dm_rd_ctrl_ID,
    input  logic [2:0]    dm_wr_ctrl_ID,
    input  logic          rf_wr_en_ID,
    input  logic [1:0]    rf_wr_sel_ID,
    input  logic          flush,
    output logic          ex_busy,
    output logic          valid_EX,
    output logic [DW-1:0] alu_result_EX,
    output logic [DW-1:0] reg_data2_EX,
    output logic [4:0]    rd_EX,
    output logic [DW-1:0] pc_EX,
    output logic [2:0]    dm_rd_ctrl_EX,
    output logic [2:0]    dm_wr_ctrl_EX,
    output logic          rf_wr_en_EX,
    output logic [1:0]    rf_wr_sel_EX
);

    localparam int unsigned CW  = $clog2(DW);
    localparam int unsigned SHW = $clog2(DW);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    op_r, op_n;
    logic [DW-1:0] a_r, a_n;
    logic [DW-1:0] b_r, b_n;
    logic [DW-1:0] q_r, q_n;
    logic [DW-1:0] acc_r, acc_n;
    logic          neg_q, neg_q_n;
    logic          neg_r, neg_r_n;

    logic          valid_n;
    logic [DW-1:0] result_n, rd2_n, pc_n;
    logic [4:0]    rd_n;
    logic [2:0]    dmr_n, dmw_n;
    logic          rfe_n;
    logic [1:0]    rfs_n;

    logic [DW-1:0] a_op, b_op, alu_c, md_c, res_c;
    logic [DW:0]   trial_c;
    logic          is_md_c, signed_c, emit_c;

    assign a_op     = alu_a_sel_ID ? pc_ID : reg_data1_ID;
    assign b_op     = alu_b_sel_ID ? imm_ID : reg_data2_ID;
    assign is_md_c  = (alu_ctrl_ID >= OP_MUL);
    assign signed_c = (alu_ctrl_ID == OP_DIV) || (alu_ctrl_ID == OP_REM);
    // Restoring-division trial subtract of the divisor magnitude
    assign trial_c  = {acc_r, q_r[DW-1]} - {1'b0, b_r};

    // Single-cycle ALU
    always_comb begin
        alu_c = '0;
        case (alu_ctrl_ID)
            OP_ADD:   alu_c = a_op + b_op;
            OP_SUB:   alu_c = a_op - b_op;
            OP_SLL:   alu_c = a_op << b_op[SHW-1:0];
            OP_SLT:   alu_c = DW'($signed(a_op) < $signed(b_op));
            OP_SLTU:  alu_c = DW'(a_op < b_op);
            OP_XOR:   alu_c = a_op ^ b_op;
            OP_SRL:   alu_c = a_op >> b_op[SHW-1:0];
            OP_SRA:   alu_c = DW'($signed(a_op) >>> b_op[SHW-1:0]);
            OP_OR:    alu_c = a_op | b_op;
            OP_AND:   alu_c = a_op & b_op;
            OP_PASSB: alu_c = b_op;
            default:  alu_c = '0;
        endcase
    end

    // Final mul/div result with RISC-V divide-by-zero and sign fix-up
    always_comb begin
        md_c = acc_r;
        case (op_r)
            OP_DIV, OP_DIVU: md_c = (b_r == '0) ? '1  : (neg_q ? -q_r : q_r);
            OP_REM, OP_REMU: md_c = (b_r == '0) ? a_r : (neg_r ? -acc_r : acc_r);
            default:         md_c = acc_r;
        endcase
    end

    // Next-state, iteration datapath and EX/MEM payload
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_r;
        a_n     = a_r;
        b_n     = b_r;
        q_n     = q_r;
        acc_n   = acc_r;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        ex_busy = 1'b0;
        emit_c  = 1'b0;
        res_c   = alu_c;

        case (state)
            IDLE: begin
                if (valid_ID && !flush) begin
                    if (is_md_c) begin
                        ex_busy = 1'b1;
                        state_n = BUSY;
                        cnt_n   = '0;
                        op_n    = alu_ctrl_ID;
                        a_n     = a_op;
                        acc_n   = '0;
                        if (alu_ctrl_ID == OP_MUL) begin
                            q_n     = a_op;
                            b_n     = b_op;
                            neg_q_n = 1'b0;
                            neg_r_n = 1'b0;
                        end else begin
                            q_n     = (signed_c && a_op[DW-1]) ? -a_op : a_op;
                            b_n     = (signed_c && b_op[DW-1]) ? -b_op : b_op;
                            neg_q_n = signed_c && (a_op[DW-1] ^ b_op[DW-1]);
                            neg_r_n = signed_c && a_op[DW-1];
                        end
                    end else begin
                        emit_c = 1'b1;
                    end
                end
            end
            BUSY: begin
                ex_busy = 1'b1;
                if (op_r == OP_MUL) begin
                    acc_n = acc_r + (q_r[0] ? b_r : '0);
                    b_n   = b_r << 1;
                    q_n   = q_r >> 1;
                end else if (!trial_c[DW]) begin
                    acc_n = trial_c[DW-1:0];
                    q_n   = {q_r[DW-2:0], 1'b1};
                end else begin
                    acc_n = {acc_r[DW-2:0], q_r[DW-1]};
                    q_n   = {q_r[DW-2:0], 1'b0};
                end
                if (cnt == CW'(DW - 1)) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                emit_c  = 1'b1;
                res_c   = md_c;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (flush) begin
            state_n = IDLE;
            emit_c  = 1'b0;
            ex_busy = 1'b0;
        end
        if (!reset) begin
            ex_busy = 1'b0;
        end

        valid_n  = 1'b0;
        result_n = '0;
        rd2_n    = '0;
        rd_n     = '0;
        pc_n     = '0;
        dmr_n    = '0;
        dmw_n    = '0;
        rfe_n    = 1'b0;
        rfs_n    = '0;
        if (emit_c) begin
            valid_n  = 1'b1;
            result_n = res_c;
            rd2_n    = reg_data2_ID;
            rd_n     = rd_ID;
            pc_n     = pc_ID;
            dmr_n    = dm_rd_ctrl_ID;
            dmw_n    = dm_wr_ctrl_ID;
            rfe_n    = rf_wr_en_ID;
            rfs_n    = rf_wr_sel_ID;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            op_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            q_r           <= '0;
            acc_r         <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            valid_EX      <= 1'b0;
            alu_result_EX <= '0;
            reg_data2_EX  <= '0;
            rd_EX         <= '0;
            pc_EX         <= '0;
            dm_rd_ctrl_EX <= '0;
            dm_wr_ctrl_EX <= '0;
            rf_wr_en_EX   <= 1'b0;
            rf_wr_sel_EX  <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            op_r          <= op_n;
            a_r           <= a_n;
            b_r           <= b_n;
            q_r           <= q_n;
            acc_r         <= acc_n;
            neg_q         <= neg_q_n;
            neg_r         <= neg_r_n;
            valid_EX      <= valid_n;
            alu_result_EX <= result_n;
            reg_data2_EX  <= rd2_n;
            rd_EX         <= rd_n;
            pc_EX         <= pc_n;
            dm_rd_ctrl_EX <= dmr_n;
            dm_wr_ctrl_EX <= dmw_n;
            rf_wr_en_EX   <= rfe_n;
            rf_wr_sel_EX  <= rfs_n;
        end
    end

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Bench for pipeline_ex_stage: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_pipeline_ex_stage;

    localparam int unsigned DW = 64;
    localparam logic [DW-1:0] MIN64 = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_ID;
    logic [DW-1:0] pc_ID, reg_data1_ID, reg_data2_ID, imm_ID;
    logic [4:0]    rd_ID;
    logic [3:0]    alu_ctrl_ID;
    logic          alu_a_sel_ID, alu_b_sel_ID;
    logic [2:0]    dm_rd_ctrl_ID, dm_wr_ctrl_ID;
    logic          rf_wr_en_ID;
    logic [1:0]    rf_wr_sel_ID;
    logic          flush;
    logic          ex_busy;
    logic          valid_EX;
    logic [DW-1:0] alu_result_EX, reg_data2_EX, pc_EX;
    logic [4:0]    rd_EX;
    logic [2:0]    dm_rd_ctrl_EX, dm_wr_ctrl_EX;
    logic          rf_wr_en_EX;
    logic [1:0]    rf_wr_sel_EX;

    int checks = 0;
    int errors = 0;

    pipeline_ex_stage #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .pc_ID(pc_ID),
        .reg_data1_ID(reg_data1_ID), .reg_data2_ID(reg_data2_ID), .imm_ID(imm_ID),
        .rd_ID(rd_ID), .alu_ctrl_ID(alu_ctrl_ID), .alu_a_sel_ID(alu_a_sel_ID),
        .alu_b_sel_ID(alu_b_sel_ID), .dm_rd_ctrl_ID(dm_rd_ctrl_ID),
        .dm_wr_ctrl_ID(dm_wr_ctrl_ID), .rf_wr_en_ID(rf_wr_en_ID),
        .rf_wr_sel_ID(rf_wr_sel_ID), .flush(flush), .ex_busy(ex_busy),
        .valid_EX(valid_EX), .alu_result_EX(alu_result_EX), .reg_data2_EX(reg_data2_EX),
        .rd_EX(rd_EX), .pc_EX(pc_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX),
        .dm_wr_ctrl_EX(dm_wr_ctrl_EX), .rf_wr_en_EX(rf_wr_en_EX), .rf_wr_sel_EX(rf_wr_sel_EX)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, observed, expected);
        end
    endtask

    function automatic logic [13:0] ex_ctl();
        return {rd_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX, rf_wr_en_EX, rf_wr_sel_EX};
    endfunction

    function automatic logic [13:0] id_ctl();
        return {rd_ID, dm_rd_ctrl_ID, dm_wr_ctrl_ID, rf_wr_en_ID, rf_wr_sel_ID};
    endfunction

    // Reference semantics straight from the ISA definitions
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        longint sa, sb;
        logic   ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MIN64) && (b == '1);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[5:0];
            4'd3:  return (sa < sb) ? 64'd1 : 64'd0;
            4'd4:  return (a < b) ? 64'd1 : 64'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[5:0];
            4'd7:  return 64'(sa >>> b[5:0]);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return a * b;
            4'd12: return (b == 0) ? '1 : (ovf ? a : 64'(sa / sb));
            4'd13: return (b == 0) ? '1 : a / b;
            4'd14: return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return MIN64;
            2:       return '1;
            3:       return 64'($urandom_range(0, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [63:0] r1, input logic [63:0] r2,
                         input logic [63:0] im, input logic [63:0] p, input logic as,
                         input logic bs);
        valid_ID      = 1'b1;
        alu_ctrl_ID   = op;
        reg_data1_ID  = r1;
        reg_data2_ID  = r2;
        imm_ID        = im;
        pc_ID         = p;
        alu_a_sel_ID  = as;
        alu_b_sel_ID  = bs;
        rd_ID         = 5'($urandom);
        dm_rd_ctrl_ID = 3'($urandom);
        dm_wr_ctrl_ID = 3'($urandom);
        rf_wr_en_ID   = 1'($urandom);
        rf_wr_sel_ID  = 2'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the result edge
    task automatic run_single(input string tag, input logic [3:0] op, input logic [63:0] r1,
                              input logic [63:0] r2, input logic [63:0] im,
                              input logic [63:0] p, input logic as, input logic bs);
        logic [63:0] expv;
        logic [13:0] ctl;
        drive(op, r1, r2, im, p, as, bs);
        expv = ref_op(op, as ? p : r1, bs ? im : r2);
        ctl  = id_ctl();
        #1;
        check(tag, "busy", 64'(ex_busy), 64'd0);
        @(posedge clk); #1;
        check(tag, "valid", 64'(valid_EX), 64'd1);
        check(tag, "result", alu_result_EX, expv);
        check(tag, "pc", pc_EX, p);
        check(tag, "rs2", reg_data2_EX, r2);
        check(tag, "ctl", 64'(ex_ctl()), 64'(ctl));
    endtask

    task automatic run_md(input string tag, input logic [3:0] op, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [63:0] im,
                          input logic [63:0] p, input logic as, input logic bs);
        logic [63:0] expv;
        logic [13:0] ctl;
        int          busy_cnt, lat;
        logic        got, bubble_ok;
        drive(op, r1, r2, im, p, as, bs);
        expv      = ref_op(op, as ? p : r1, bs ? im : r2);
        ctl       = id_ctl();
        busy_cnt  = 0;
        lat       = 0;
        got       = 1'b0;
        bubble_ok = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (ex_busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
            if (valid_EX) begin
                got = 1'b1;
                break;
            end
            if (alu_result_EX != 0 || pc_EX != 0 || reg_data2_EX != 0 || ex_ctl() != 0)
                bubble_ok = 1'b0;
        end
        check(tag, "arrived", 64'(got), 64'd1);
        check(tag, "latency", 64'(lat), 64'(DW + 2));
        check(tag, "busy_cycles", 64'(busy_cnt), 64'(DW + 1));
        check(tag, "bubbles", 64'(bubble_ok), 64'd1);
        check(tag, "result", alu_result_EX, expv);
        check(tag, "pc", pc_EX, p);
        check(tag, "ctl", 64'(ex_ctl()), 64'(ctl));
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid_EX || ex_busy) seen = 1'b1;
        end
        check(tag, "no_late_result", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] r1, r2, im, p;
        logic        as, bs;

        reset = 1'b0;
        flush = 1'b0;
        drive(4'd11, 64'd9, 64'd9, 64'd0, 64'h40, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", "valid", 64'(valid_EX), 64'd0);
        check("reset", "result", alu_result_EX, 64'd0);
        check("reset", "pc", pc_EX, 64'd0);
        check("reset", "rs2", reg_data2_EX, 64'd0);
        check("reset", "ctl", 64'(ex_ctl()), 64'd0);
        check("reset", "busy", 64'(ex_busy), 64'd0);
        valid_ID = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;

        run_single("add_imm", 4'd0, 64'd5, 64'd77, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1000, 1'b0, 1'b1);
        check("add_imm", "const", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFE);
        run_single("sra", 4'd7, MIN64, 64'd4, 64'd0, 64'h1004, 1'b0, 1'b0);
        check("sra", "const", alu_result_EX, 64'hF800_0000_0000_0000);
        run_single("srl", 4'd6, MIN64, 64'd4, 64'd0, 64'h1008, 1'b0, 1'b0);
        check("srl", "const", alu_result_EX, 64'h0800_0000_0000_0000);
        run_single("sltu", 4'd4, '1, 64'd1, 64'd0, 64'h100C, 1'b0, 1'b0);
        check("sltu", "const", alu_result_EX, 64'd0);
        run_single("slt", 4'd3, '1, 64'd1, 64'd0, 64'h1010, 1'b0, 1'b0);
        run_single("auipc", 4'd0, 64'd0, 64'd0, 64'h20, 64'h2000, 1'b1, 1'b1);

        run_md("mul", 4'd11, 64'h1_0000_0001, 64'd3, 64'd0, 64'h1014, 1'b0, 1'b0);
        check("mul", "const", alu_result_EX, 64'h3_0000_0003);
        run_md("div0", 4'd12, 64'd7, 64'd0, 64'd0, 64'h1018, 1'b0, 1'b0);
        run_md("rem0", 4'd14, 64'd7, 64'd0, 64'd0, 64'h101C, 1'b0, 1'b0);
        check("rem0", "const", alu_result_EX, 64'd7);
        run_md("div_ovf", 4'd12, MIN64, '1, 64'd0, 64'h1020, 1'b0, 1'b0);
        check("div_ovf", "const", alu_result_EX, MIN64);
        run_md("rem_ovf", 4'd14, MIN64, '1, 64'd0, 64'h1024, 1'b0, 1'b0);
        run_md("rem_neg", 4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 64'h1028, 1'b0, 1'b0);
        check("rem_neg", "const", alu_result_EX, '1);
        run_md("divu0", 4'd13, 64'd7, 64'd0, 64'd0, 64'h102C, 1'b0, 1'b0);

        // Flush of a single-cycle op yields a bubble
        drive(4'd0, 64'd1, 64'd2, 64'd0, 64'h3000, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_alu", "busy", 64'(ex_busy), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_alu", "valid", 64'(valid_EX), 64'd0);
        check("flush_alu", "result", alu_result_EX, 64'd0);

        // Flush in the middle of a multiply
        drive(4'd11, 64'd12345, 64'd678, 64'd0, 64'h3004, 1'b0, 1'b0);
        #1;
        check("flush_md", "busy_start", 64'(ex_busy), 64'd1);
        repeat (11) @(posedge clk);
        #1;
        check("flush_md", "busy_mid", 64'(ex_busy), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_md", "busy_flush", 64'(ex_busy), 64'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        valid_ID = 1'b0;
        check("flush_md", "valid", 64'(valid_EX), 64'd0);
        check("flush_md", "result", alu_result_EX, 64'd0);
        check("flush_md", "busy_after", 64'(ex_busy), 64'd0);
        watch_quiet("flush_md", 80);
        run_single("after_flush", 4'd1, 64'd10, 64'd3, 64'd0, 64'h3008, 1'b0, 1'b0);

        // Reset pulse in the middle of a divide
        drive(4'd12, 64'd1000, 64'd7, 64'd0, 64'h3010, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("reset_md", "valid", 64'(valid_EX), 64'd0);
        check("reset_md", "result", alu_result_EX, 64'd0);
        check("reset_md", "ctl", 64'(ex_ctl()), 64'd0);
        check("reset_md", "busy", 64'(ex_busy), 64'd0);
        valid_ID = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        watch_quiet("reset_md", 80);

        // Back-to-back ADD, MUL, ADD
        run_single("b2b_add1", 4'd0, 64'd100, 64'd23, 64'd0, 64'h4000, 1'b0, 1'b0);
        run_md("b2b_mul", 4'd11, 64'hDEAD_BEEF, 64'h1234_5678, 64'd0, 64'h4004, 1'b0, 1'b0);
        run_single("b2b_add2", 4'd0, 64'd1, 64'd2, 64'd0, 64'h4008, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            r1 = rand64();
            r2 = rand64();
            im = rand64();
            p  = {$urandom, $urandom};
            as = 1'($urandom);
            bs = 1'($urandom);
            if (op >= 4'd11) run_md("rand_md", op, r1, r2, im, p, as, bs);
            else             run_single("rand_alu", op, r1, r2, im, p, as, bs);
        end
        valid_ID = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
